// File: rtl/intt_gs2_pkg.sv
// Shared widths and pipeline delays for the INTT butterfly datapath.
// Mirrors the values of the common width/delay defines so every file agrees.
package intt_gs2_pkg;

  localparam int DATA_SIZE_ARB = 14;
  localparam int INTMUL_DELAY  = 1;
  localparam int MODRED_DELAY  = 2;

endpackage

// File: rtl/intt_gs2_if.sv
// Operand/result bundle between the coefficient RAM read side and the butterfly.
// Valid-only streaming: in_valid/out_valid/odd_valid qualify data in the same cycle; there is no ready, no stall.
interface intt_gs2_if #(
  parameter int DATA_SIZE = intt_gs2_pkg::DATA_SIZE_ARB
);

  logic                 in_valid;
  logic                 half_en;
  logic [DATA_SIZE-1:0] q;
  logic [DATA_SIZE-1:0] INTTin0;
  logic [DATA_SIZE-1:0] INTTin1;
  logic [DATA_SIZE-1:0] MULin;
  logic [DATA_SIZE-1:0] ADDout;
  logic [DATA_SIZE-1:0] MULout;
  logic                 out_valid;
  logic [DATA_SIZE-1:0] INTToutEVEN;
  logic [DATA_SIZE-1:0] INTToutODD;
  logic                 odd_valid;

  modport master (
    output in_valid, half_en, q, INTTin0, INTTin1, MULin,
    input  ADDout, MULout, out_valid, INTToutEVEN, INTToutODD, odd_valid
  );

  modport slave (
    input  in_valid, half_en, q, INTTin0, INTTin1, MULin,
    output ADDout, MULout, out_valid, INTToutEVEN, INTToutODD, odd_valid
  );

endinterface

// File: rtl/ModMult.sv
// Pipelined modular multiplier c = a*b mod q with a fixed latency of DELAY cycles (DELAY >= 2).
// One register after the integer multiply, then reduction followed by DELAY-1 retimable registers.
module ModMult #(
  parameter int DATA_SIZE = 14,
  parameter int DELAY     = 3
) (
  input  logic                 clk,
  input  logic [DATA_SIZE-1:0] a_i,
  input  logic [DATA_SIZE-1:0] b_i,
  input  logic [DATA_SIZE-1:0] q_i,
  output logic [DATA_SIZE-1:0] c_o
);

  localparam int W = DATA_SIZE;

  logic [2*W-1:0] prod_q;
  logic [W-1:0]   red;
  logic [W-1:0]   pipe_q [DELAY-1];

  // Restoring shift-subtract reduction; the remainder stays below q so 2r+1 fits W+1 bits.
  function automatic logic [W-1:0] mod_reduce(input logic [2*W-1:0] p, input logic [W-1:0] m);
    logic [W:0] r;
    r = '0;
    for (int i = 2*W-1; i >= 0; i--) begin
      r = {r[W-1:0], p[i]};
      if (r >= {1'b0, m}) r = r - {1'b0, m};
    end
    return r[W-1:0];
  endfunction

  // No reset: stale contents are never flagged because valid travels alongside.
  always_ff @(posedge clk) begin
    prod_q <= {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};
  end

  assign red = mod_reduce(prod_q, q_i);

  always_ff @(posedge clk) begin
    pipe_q[0] <= red;
    for (int i = 1; i < DELAY-1; i++) pipe_q[i] <= pipe_q[i-1];
  end

  assign c_o = pipe_q[DELAY-2];

endmodule

// File: rtl/ShiftReg.sv
// Fixed-depth delay line with asynchronous clear, used to align side data with ModMult.
module ShiftReg #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/intt_gs2_mod_half.sv
// Combinational x/2 mod q for odd q and x < q; also reusable by the final INTT scaling stage.
module intt_gs2_mod_half #(
  parameter int DATA_SIZE = 14
) (
  input  logic [DATA_SIZE-1:0] x_i,
  input  logic [DATA_SIZE-1:0] q_i,
  output logic [DATA_SIZE-1:0] y_o
);

  logic [DATA_SIZE:0] evened;

  // Odd x plus odd q is even, so the shift is exact and the result stays below q.
  assign evened = {1'b0, x_i} + (x_i[0] ? {1'b0, q_i} : '0);
  assign y_o    = DATA_SIZE'(evened >> 1);

endmodule

// File: rtl/intt_gs2.sv
// Gentleman-Sande inverse-NTT butterfly: sum=(a+b) mod q, prod=((a-b) mod q)*w mod q, optional halving.
// Results appear L = MUL_DELAY+2 cycles after in_valid; the odd (product) leg repeats one cycle later.
module intt_gs2
  import intt_gs2_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_ARB,
  parameter int MUL_DELAY = INTMUL_DELAY + MODRED_DELAY
) (
  input  logic        clk,
  input  logic        reset,
  intt_gs2_if.slave   bus
);

  localparam int W = DATA_SIZE;

  logic [W:0]   sum_raw;
  logic [W:0]   diff_raw;
  logic [W-1:0] sum_mod;
  logic [W-1:0] diff_mod;
  logic [W-1:0] sum_half;
  logic [W-1:0] diff_half;

  logic [W-1:0] s1_sum_d, s1_sum_q;
  logic [W-1:0] s1_diff_d, s1_diff_q;
  logic [W-1:0] s1_w_q;
  logic         s1_valid_q;

  logic [W-1:0] prod;
  logic [W-1:0] sum_dly;
  logic         valid_dly;

  logic [W-1:0] add_q;
  logic [W-1:0] mul_q;
  logic         out_valid_q;
  logic [W-1:0] odd_q;
  logic         odd_valid_q;

  // Stage S1: modular add/sub at W+1 bits, then optional halving of both legs.
  always_comb begin
    sum_raw  = {1'b0, bus.INTTin0} + {1'b0, bus.INTTin1};
    sum_mod  = (sum_raw >= {1'b0, bus.q}) ? W'(sum_raw - {1'b0, bus.q}) : sum_raw[W-1:0];
    diff_raw = {1'b0, bus.INTTin0} - {1'b0, bus.INTTin1};
    diff_mod = diff_raw[W] ? (diff_raw[W-1:0] + bus.q) : diff_raw[W-1:0];
  end

  intt_gs2_mod_half #(.DATA_SIZE(W)) u_half_sum (
    .x_i (sum_mod),
    .q_i (bus.q),
    .y_o (sum_half)
  );

  intt_gs2_mod_half #(.DATA_SIZE(W)) u_half_diff (
    .x_i (diff_mod),
    .q_i (bus.q),
    .y_o (diff_half)
  );

  always_comb begin
    s1_sum_d  = bus.half_en ? sum_half  : sum_mod;
    s1_diff_d = bus.half_en ? diff_half : diff_mod;
  end

  // Data loads every cycle; only the valid flag qualifies it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_sum_q   <= '0;
      s1_diff_q  <= '0;
      s1_w_q     <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_sum_q   <= s1_sum_d;
      s1_diff_q  <= s1_diff_d;
      s1_w_q     <= bus.MULin;
      s1_valid_q <= bus.in_valid;
    end
  end

  // Stage S2: multiplier plus matching delay lines for the sum leg and valid.
  ModMult #(.DATA_SIZE(W), .DELAY(MUL_DELAY)) u_mul (
    .clk (clk),
    .a_i (s1_diff_q),
    .b_i (s1_w_q),
    .q_i (bus.q),
    .c_o (prod)
  );

  ShiftReg #(.WIDTH(W), .DEPTH(MUL_DELAY)) u_sum_dly (
    .clk (clk),
    .rst (reset),
    .d_i (s1_sum_q),
    .q_o (sum_dly)
  );

  ShiftReg #(.WIDTH(1), .DEPTH(MUL_DELAY)) u_valid_dly (
    .clk (clk),
    .rst (reset),
    .d_i (s1_valid_q),
    .q_o (valid_dly)
  );

  // Stages S3 (parallel result) and S4 (odd leg of the serialized pair).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      add_q       <= '0;
      mul_q       <= '0;
      out_valid_q <= 1'b0;
      odd_q       <= '0;
      odd_valid_q <= 1'b0;
    end else begin
      add_q       <= sum_dly;
      mul_q       <= prod;
      out_valid_q <= valid_dly;
      odd_q       <= mul_q;
      odd_valid_q <= out_valid_q;
    end
  end

  assign bus.ADDout      = add_q;
  assign bus.INTToutEVEN = add_q;
  assign bus.MULout      = mul_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.INTToutODD  = odd_q;
  assign bus.odd_valid   = odd_valid_q;

endmodule
